// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: register defaults and hazard controller constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Register 0 is hard-wired to zero and never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Hazard controller FSM encodings.
  localparam logic [1:0] HC_RUN     = 2'd0;
  localparam logic [1:0] HC_MD_WAIT = 2'd1;
  localparam logic [1:0] HC_ERR     = 2'd2;

  // Default number of consecutive stall cycles before the watchdog trips.
  localparam int HC_MAX_WAIT_DEF = 64;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard decode between the instruction in ID and a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides how to stall.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_regread1,
  input  logic       ID_regread2,
  input  logic       EX_memread,
  input  logic [4:0] EX_wraddr,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // A hit only matters if ID really reads that operand.
  assign rs_hit   = ID_regread1 & (ID_rs == EX_wraddr);
  assign rt_hit   = ID_regread2 & (ID_rt == EX_wraddr);
  assign load_use = EX_memread & (EX_wraddr != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, EX redirect, dmem wait, mult/div wait, watchdog.
// Latency: stall/flush outputs combinational (same cycle); FSM/counters update on clk.
// Backpressure: mem wait freezes PC..EX_MEM, mult/div freezes PC..ID_EX; ERR freezes all.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = HC_MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_regread1,
  input  logic             ID_regread2,
  input  logic             EX_memread,
  input  logic [4:0]       EX_wraddr,
  input  logic             EX_redirect,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // wcnt only needs to reach MAX_WAIT-1; it holds there once reached.
  localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              load_use;
  logic              mem_wait;
  logic              md_wait;
  logic              wcnt_last;

  hazard_detect u_detect (
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_regread1 (ID_regread1),
    .ID_regread2 (ID_regread2),
    .EX_memread  (EX_memread),
    .EX_wraddr   (EX_wraddr),
    .load_use    (load_use)
  );

  assign mem_wait    = dmem_req & ~dmem_ack;
  // muldiv_start only counts in RUN: the held instruction keeps asserting it while waiting.
  assign md_wait     = ((state == HC_MD_WAIT) | ((state == HC_RUN) & muldiv_start)) & ~muldiv_done;
  assign wcnt_last   = (wcnt == WCNT_LAST);
  assign err_timeout = (state == HC_ERR);

  // Prioritised stall/flush decode; a redirect under a stall is deferred because EX is held.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    if (!rst_n) begin
      // Pipeline registers are being reset anyway; keep all controls quiet.
    end else if (state == HC_ERR) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (md_wait) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (EX_redirect) begin
      // The ID instruction is on the wrong path, so any load-use on it is moot.
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_flush  = 1'b1;
    end
  end

  // Next-state: watchdog trip wins, ERR is terminal until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      HC_RUN: begin
        if (pc_stall && wcnt_last)
          state_nxt = HC_ERR;
        else if (muldiv_start && !muldiv_done && !mem_wait)
          state_nxt = HC_MD_WAIT;
      end
      HC_MD_WAIT: begin
        if (pc_stall && wcnt_last)
          state_nxt = HC_ERR;
        else if (muldiv_done)
          state_nxt = HC_RUN;
      end
      HC_ERR:  state_nxt = HC_ERR;
      default: state_nxt = HC_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= HC_RUN;
    else
      state <= state_nxt;
  end

  // Consecutive-stall watchdog counter, cleared by any free-running cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wcnt <= '0;
    else if (!pc_stall)
      wcnt <= '0;
    else if (!wcnt_last)
      wcnt <= wcnt + 1'b1;
  end

  // Saturating total stall-cycle counter for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized model comparison.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int MAXW = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    ID_rs, ID_rt, EX_wraddr;
  logic          ID_regread1, ID_regread2, EX_memread, EX_redirect;
  logic          muldiv_start, muldiv_done, dmem_req, dmem_ack;
  logic          pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic          IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic          err_timeout;
  logic [CW-1:0] stall_cycles;
  logic [7:0]    obs;

  int n_vec = 0;
  int n_bad = 0;

  // Expected-output patterns: {pc,IF_ID,ID_EX,EX_MEM stall, IF_ID,ID_EX,EX_MEM,MEM_WB flush}
  localparam logic [7:0] P_NONE = 8'b0000_0000;
  localparam logic [7:0] P_ERR  = 8'b1111_0000;
  localparam logic [7:0] P_MEM  = 8'b1111_0001;
  localparam logic [7:0] P_MD   = 8'b1110_0010;
  localparam logic [7:0] P_RDR  = 8'b0000_1100;
  localparam logic [7:0] P_LU   = 8'b1100_0100;

  always #5 clk = ~clk;

  assign obs = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

  hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_regread1(ID_regread1), .ID_regread2(ID_regread2),
    .EX_memread(EX_memread), .EX_wraddr(EX_wraddr), .EX_redirect(EX_redirect),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .err_timeout(err_timeout), .stall_cycles(stall_cycles)
  );

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_regread1 = 1'b0; ID_regread2 = 1'b0;
    EX_memread = 1'b0; EX_wraddr = 5'd0; EX_redirect = 1'b0;
    muldiv_start = 1'b0; muldiv_done = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Pulse reset across one rising edge; inputs change 1 time unit after the edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Advance from the sampling point (negedge) to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    dmem_req = 1'b1; EX_redirect = 1'b1; muldiv_start = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== P_NONE) begin
      n_bad++; $display("FAIL reset_outputs got %b want %b", obs, P_NONE);
    end
    n_vec++;
    if (err_timeout !== 1'b0 || stall_cycles !== '0) begin
      n_bad++; $display("FAIL reset_regs got err=%b cnt=%0d want err=0 cnt=0", err_timeout, stall_cycles);
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_memread = 1'b1; EX_wraddr = 5'd5; ID_rs = 5'd5; ID_regread1 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== P_LU) begin
      n_bad++; $display("FAIL load_use got %b want %b", obs, P_LU);
    end
    next_cycle();
    // Load has moved on to MEM: the hazard is gone.
    EX_memread = 1'b0; EX_wraddr = 5'd9;
    @(negedge clk);
    n_vec++;
    if (obs !== P_NONE) begin
      n_bad++; $display("FAIL load_use_clear got %b want %b", obs, P_NONE);
    end
    next_cycle();
    EX_memread = 1'b1; EX_wraddr = 5'd0; ID_rs = 5'd0;
    @(negedge clk);
    n_vec++;
    if (obs !== P_NONE) begin
      n_bad++; $display("FAIL load_use_r0 got %b want %b", obs, P_NONE);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_muldiv();
    do_reset();
    muldiv_start = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      muldiv_done = (c == 4);
      @(negedge clk);
      n_vec++;
      if (obs !== ((c < 4) ? P_MD : P_NONE)) begin
        n_bad++; $display("FAIL muldiv_c%0d got %b want %b", c, obs, (c < 4) ? P_MD : P_NONE);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (stall_cycles !== CW'(4)) begin
      n_bad++; $display("FAIL muldiv_count got %0d want 4", stall_cycles);
    end
    // Back in RUN: a fresh start must stall again.
    muldiv_start = 1'b1;
    #1;
    n_vec++;
    if (obs !== P_MD) begin
      n_bad++; $display("FAIL muldiv_rerun got %b want %b", obs, P_MD);
    end
    muldiv_done = 1'b1;
    #1;
    n_vec++;
    if (obs !== P_NONE) begin
      n_bad++; $display("FAIL muldiv_same_cycle got %b want %b", obs, P_NONE);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    EX_memread = 1'b1; EX_wraddr = 5'd7; ID_rt = 5'd7; ID_regread2 = 1'b1; EX_redirect = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== P_RDR) begin
      n_bad++; $display("FAIL redirect_lu got %b want %b", obs, P_RDR);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_mem_wait_redirect();
    do_reset();
    dmem_req = 1'b1; EX_redirect = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      dmem_ack = (c == 3);
      @(negedge clk);
      n_vec++;
      if (obs !== ((c < 3) ? P_MEM : P_RDR)) begin
        n_bad++; $display("FAIL memwait_c%0d got %b want %b", c, obs, (c < 3) ? P_MEM : P_RDR);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    dmem_req = 1'b1;
    for (int c = 0; c < MAXW; c++) begin
      @(negedge clk);
      n_vec++;
      if (err_timeout !== 1'b0 || obs !== P_MEM) begin
        n_bad++; $display("FAIL wdog_pre_c%0d got err=%b out=%b want err=0 out=%b", c, err_timeout, obs, P_MEM);
      end
      next_cycle();
    end
    dmem_ack = 1'b1; EX_redirect = 1'b1;
    @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b1 || obs !== P_ERR) begin
      n_bad++; $display("FAIL wdog_trip got err=%b out=%b want err=1 out=%b", err_timeout, obs, P_ERR);
    end
    // Asynchronous reset mid-error.
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (err_timeout !== 1'b0 || stall_cycles !== '0 || obs !== P_NONE) begin
      n_bad++; $display("FAIL wdog_reset got err=%b cnt=%0d out=%b want 0 0 %b", err_timeout, stall_cycles, obs, P_NONE);
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    muldiv_start = 1'b1;
    #1;
    n_vec++;
    if (obs !== P_MD) begin
      n_bad++; $display("FAIL wdog_run_after_reset got %b want %b", obs, P_MD);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1'b1;
    repeat (20) next_cycle();
    @(negedge clk);
    n_vec++;
    if (stall_cycles !== CW'(15)) begin
      n_bad++; $display("FAIL saturation got %0d want 15", stall_cycles);
    end
    n_vec++;
    if (obs !== P_ERR) begin
      n_bad++; $display("FAIL saturation_err got %b want %b", obs, P_ERR);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Reference model: tracks "a mult/div is outstanding", "watchdog tripped",
  // the length of the current stall run and the total stall count.
  task automatic test_random();
    bit   m_md, m_err, mw, lu, mdw, st;
    int   run_len, total;
    logic [7:0] exp;
    do_reset();
    m_md = 0; m_err = 0; run_len = 0; total = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        m_md = 0; m_err = 0; run_len = 0; total = 0;
      end
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      EX_wraddr    = 5'($urandom_range(0, 3));
      ID_regread1  = 1'($urandom_range(0, 1));
      ID_regread2  = 1'($urandom_range(0, 1));
      EX_memread   = 1'($urandom_range(0, 1));
      EX_redirect  = ($urandom_range(0, 3) == 0);
      muldiv_start = ($urandom_range(0, 3) == 0);
      muldiv_done  = ($urandom_range(0, 2) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ack     = 1'($urandom_range(0, 1));

      mw  = dmem_req && !dmem_ack;
      lu  = EX_memread && (EX_wraddr != 0) &&
            ((ID_regread1 && ID_rs == EX_wraddr) || (ID_regread2 && ID_rt == EX_wraddr));
      mdw = !m_err && (m_md || muldiv_start) && !muldiv_done;
      if (m_err)            exp = P_ERR;
      else if (mw)          exp = P_MEM;
      else if (mdw)         exp = P_MD;
      else if (EX_redirect) exp = P_RDR;
      else if (lu)          exp = P_LU;
      else                  exp = P_NONE;

      @(negedge clk);
      n_vec++;
      if (obs !== exp || err_timeout !== m_err ||
          stall_cycles !== CW'((total > 15) ? 15 : total)) begin
        n_bad++;
        $display("FAIL random_%0d got out=%b err=%b cnt=%0d want out=%b err=%b cnt=%0d",
                 i, obs, err_timeout, stall_cycles, exp, m_err, (total > 15) ? 15 : total);
      end

      st = exp[7];
      if (st) begin run_len++; total++; end
      else run_len = 0;
      if (!m_err) begin
        if (m_md) m_md = !muldiv_done;
        else      m_md = muldiv_start && !muldiv_done && !mw;
      end
      if (st && run_len >= MAXW) begin m_err = 1; m_md = 0; end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_muldiv();
    test_redirect_load_use();
    test_mem_wait_redirect();
    test_watchdog();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. Sequences the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC through their stall/flush inputs. Covers four stall sources:

- load-use hazards;
- branch/jump redirects resolved in EX;
- multi-cycle data-memory waits in MEM;
- multi-cycle mult/div operations in EX.

It also contains a stall watchdog and a saturating stall-cycle counter.

## Interface
- MAX_WAIT, 64: consecutive stall cycles that trip the watchdog (≥2).
- CNT_W, 16: width of stall-cycle counter.
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
- ID_regread1, ID_regread2  in  1 each  ID actually reads rs / rt.
- EX_memread  in  1  instruction in EX is a load.
- EX_wraddr  in  5  destination register of the instruction in EX.
- EX_redirect  in  1  taken branch/jump/jr resolved in EX.
- muldiv_start  in  1  instruction in EX starts a mult/div.
- muldiv_done  in  1  mult/div result ready this cycle.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ack  in  1  data memory completes this cycle.
- pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold the register.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a bubble (NOP, controls 0).
- err_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

## Operation
- **Registered state:**
  - FSM state {RUN, MD_WAIT, ERR};
  - wait counter wcnt;
  - stall_cycles.
- **Combinational decode:**
  - mem_wait = dmem_req & !dmem_ack.
  - load_use = EX_memread & EX_wraddr≠0 & ((ID_regread1 & ID_rs==EX_wraddr) | (ID_regread2 & ID_rt==EX_wraddr)).
  - md_wait = (state==MD_WAIT | (state==RUN & muldiv_start)) & !muldiv_done.
- **Output priority, highest first.** Outputs not listed are 0.
  1. **ERR:** all four stalls = 1, all flushes = 0.
  2. **mem_wait:** pc/IF_ID/ID_EX/EX_MEM stall = 1, MEM_WB_flush = 1.
  3. **md_wait:** pc/IF_ID/ID_EX stall = 1, EX_MEM_flush = 1.
  4. **EX_redirect:** IF_ID_flush = 1, ID_EX_flush = 1, no stalls. This overrides a coincident load_use, because the ID instruction is on the wrong path.
  5. **load_use:** pc/IF_ID stall = 1, ID_EX_flush = 1.
- **Deferred redirect:** a redirect coincident with mem_wait or md_wait is not flushed that cycle. EX is held, so EX_redirect stays asserted and acts on the first unstalled cycle.
- **FSM transitions:**
  - RUN→MD_WAIT when muldiv_start & !muldiv_done & !mem_wait.
  - MD_WAIT→RUN when muldiv_done.
  - muldiv_start is ignored outside RUN, because the held instruction keeps asserting it.
  - muldiv_start with muldiv_done in the same cycle causes no stall.
  - Any state→ERR when wcnt reaches MAX_WAIT−1 while pc_stall=1.
  - ERR is left only by reset.
- **Watchdog counter:**
  - wcnt increments on every cycle with pc_stall=1.
  - wcnt clears on any cycle with pc_stall=0.
  - err_timeout = (state==ERR).
- **Stall counter:** stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).
- **mem_wait inside MD_WAIT:** mem_wait priority applies. The FSM stays in MD_WAIT, and muldiv_done is still honoured for the transition.

## Timing
- All stall/flush outputs are combinational from current state and inputs: same-cycle effect on the pipeline registers.
- **Reset:**
  - state=RUN, wcnt=0, stall_cycles=0, err_timeout=0.
  - While rst_n=0, all stall/flush outputs are forced to 0.
- **Load-use:** exactly 1 bubble cycle, because the load moves to MEM the next cycle and the hazard clears.
- **Mult/div:**
  - Stall lasts from the start cycle through the cycle before muldiv_done.
  - The done cycle advances the pipeline.
- **Memory wait:** stall lasts every cycle with req & !ack. The ack cycle advances the pipeline.
- **Reset mid-wait:** returns to RUN immediately, and counters clear.

## Structure
- Add to the shared header alongside the existing NOP/register defaults:
  - state encodings HC_RUN=2'd0, HC_MD_WAIT=2'd1, HC_ERR=2'd2;
  - default MAX_WAIT.
- One combinational sub-module, hazard_detect (load_use decode), reusable by a forwarding unit. All else is in hazard_ctrl.

## Test plan
- **Load-use:** EX_memread=1, EX_wraddr=5, ID_rs=5, ID_regread1=1 → pc_stall=IF_ID_stall=ID_EX_flush=1 for 1 cycle. The same stimulus with EX_wraddr=0 → no stall.
- **Mult/div:** muldiv_start at cycle 0, muldiv_done at cycle 4 → pc/IF_ID/ID_EX stall and EX_MEM_flush in cycles 0–3, none in cycle 4, state back to RUN, stall_cycles=4.
- **Redirect + load-use:** EX_redirect and load_use in the same cycle → IF_ID_flush=ID_EX_flush=1, pc_stall=0.
- **Memory wait with redirect:** dmem_req=1, ack low 3 cycles, with EX_redirect=1 throughout → 3 cycles of 4 stalls plus MEM_WB_flush, no IF_ID_flush. In the ack cycle, IF_ID_flush=ID_EX_flush=1.
- **Watchdog:** MAX_WAIT=8, dmem_ack held 0 → err_timeout rises after 8 stall cycles, all stalls stay 1. Asserting rst_n=0 clears err_timeout, state=RUN, stall_cycles=0.
- **Counter saturation:** CNT_W=4, 20 stall cycles → stall_cycles=15.
